// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix strobes/returns plus the debounced key report.
// Latency: n/a (wiring only).
// Backpressure: none; key_valid is a fire-and-forget pulse with no ready.
//
// Signals:
//   ROW       keypad row returns, active-low, asynchronous to the scanner clock
//   COL       column strobes, active-low one-hot
//   key_code  debounced key index, row*4 + col
//   key_valid one-cycle pulse when key_code takes a newly accepted key
//   key_down  high while an accepted key is held
interface keypad_scanner_if;
   logic [3:0] ROW;
   logic [3:0] COL;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;

   // scanner side
   modport master (
      input  ROW,
      output COL, key_code, key_valid, key_down
   );

   // keypad / consumer side
   modport slave (
      output ROW,
      input  COL, key_code, key_valid, key_down
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-scan debounce and single-key reporting.
// Latency: press to key_valid at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 4 clk.
// Backpressure: none; key_valid pulses once per newly accepted key.
//
// Ports:
//   clk   system clock
//   clr   asynchronous active-low reset
//   kp    keypad_scanner_if.master: ROW in, COL / key_code / key_valid / key_down out
module keypad_scanner #(
   parameter int SCAN_DIV       = 5000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic             clk,
   input  logic             clr,
   keypad_scanner_if.master kp
);

   localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
   localparam logic [3:0]  STABLE_MAX = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      RES_NONE   = 2'd0,
      RES_SINGLE = 2'd1,
      RES_MULTI  = 2'd2
   } res_kind_t;

   typedef struct packed {
      res_kind_t  kind;
      logic [3:0] code;
   } scan_res_t;

   logic [3:0]  row_s1;
   logic [3:0]  row_s2;
   logic [15:0] dwell;
   logic [1:0]  col_idx;
   logic [3:0]  col_q;
   logic [1:0]  acc_cnt;
   logic [3:0]  acc_first;
   scan_res_t   prev_res;
   logic [3:0]  stable_cnt;
   logic        eval_pend;
   logic [3:0]  code_q;
   logic        valid_q;
   logic        down_q;

   logic        sample_now;
   logic        scan_end;
   logic [2:0]  hits;
   logic [1:0]  hit_row;
   logic [1:0]  base_cnt;
   logic [3:0]  base_first;
   logic [2:0]  sum_cnt;
   logic [1:0]  new_cnt;
   logic [3:0]  new_first;
   scan_res_t   scan_res;

   function automatic logic [3:0] col_strobe(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

   // Per-sample accumulation. Column 0 starts from an empty accumulator, so
   // no separate clear cycle is needed. Columns are visited in ascending
   // order, so the first hit recorded is already the lowest column; within a
   // column the downward loop leaves the lowest pressed row.
   always_comb begin
      sample_now = (dwell == DWELL_LAST);
      scan_end   = sample_now && (col_idx == 2'd3);
      hits       = 3'd0;
      hit_row    = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (!row_s2[r]) begin
            hits    = hits + 3'd1;
            hit_row = 2'(r);
         end
      end
      base_cnt   = (col_idx == 2'd0) ? 2'd0 : acc_cnt;
      base_first = (col_idx == 2'd0) ? 4'd0 : acc_first;
      sum_cnt    = {1'b0, base_cnt} + hits;
      new_cnt    = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
      new_first  = (base_cnt == 2'd0 && hits != 3'd0) ? {hit_row, col_idx} : base_first;
      scan_res      = '0;
      scan_res.kind = (new_cnt == 2'd0) ? RES_NONE :
                      (new_cnt == 2'd1) ? RES_SINGLE : RES_MULTI;
      scan_res.code = (new_cnt == 2'd1) ? new_first : 4'd0;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         row_s1     <= 4'b1111;
         row_s2     <= 4'b1111;
         dwell      <= 16'd0;
         col_idx    <= 2'd0;
         col_q      <= 4'b1110;
         acc_cnt    <= 2'd0;
         acc_first  <= 4'd0;
         prev_res   <= '0;
         stable_cnt <= 4'd0;
         eval_pend  <= 1'b0;
         code_q     <= 4'd0;
         valid_q    <= 1'b0;
         down_q     <= 1'b0;
      end else begin
         row_s1    <= kp.ROW;
         row_s2    <= row_s1;
         eval_pend <= 1'b0;
         valid_q   <= 1'b0;

         // COL moves together with the column index, so the row returns get
         // the whole dwell (minus the sample cycle) to settle through the
         // synchronizer before they are sampled.
         if (sample_now) begin
            dwell     <= 16'd0;
            col_idx   <= col_idx + 2'd1;
            col_q     <= col_strobe(col_idx + 2'd1);
            acc_cnt   <= new_cnt;
            acc_first <= new_first;
            if (scan_end) begin
               if (scan_res == prev_res) begin
                  if (stable_cnt < STABLE_MAX) stable_cnt <= stable_cnt + 4'd1;
               end else begin
                  stable_cnt <= 4'd1;
                  prev_res   <= scan_res;
               end
               eval_pend <= 1'b1;
            end
         end else begin
            dwell <= dwell + 16'd1;
         end

         // Acceptance runs one cycle after the scan closes, on the updated
         // debounce state.
         if (eval_pend && stable_cnt == STABLE_MAX) begin
            unique case (prev_res.kind)
               RES_SINGLE: begin
                  if (!down_q || code_q != prev_res.code) begin
                     code_q  <= prev_res.code;
                     down_q  <= 1'b1;
                     valid_q <= 1'b1;
                  end
               end
               RES_NONE: down_q <= 1'b0;
               default:  ;
            endcase
         end
      end
   end

   assign kp.COL       = col_q;
   assign kp.key_code  = code_q;
   assign kp.key_valid = valid_q;
   assign kp.key_down  = down_q;

endmodule
